bus_if: RTL and testbench

External bus interface sitting directly downstream of the memory controller: it accepts single load/store/fetch requests (`bus_en`, `bus_wr_en`, `bus_addr`, `bus_wr_data`, `bus_access_size`) and runs them as request/acknowledge transactions on the off-core memory bus. It returns `ext_read_data` and a one-cycle `bus_ack` to the controller. The same path serves PRAM initialization on reset, instruction fetch from external memory and external load/store.

---
 rtl/bus_if_pkg.sv | 20 ++
 rtl/bus_if_lane_align.sv | 44 ++++
 rtl/bus_if.sv | 158 +++++++++++++++
 tb/tb_bus_if.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_if_pkg.sv
// bus_if_pkg: shared definitions for the external bus interface.
//   - access-size encodings presented on bus_access_size
//   - FSM state enum for the request/acknowledge sequencer
//   - default timeout length, used only when BUS_IF_TIMEOUT_EN is defined
package bus_if_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is reserved and behaves as a word

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_GAP
  } state_e;

endpackage

// File: rtl/bus_if_lane_align.sv
// bus_if_lane_align: combinational lane steering for the external bus.
// Ports:
//   size          in  2   access size (byte/half/word, 11 treated as word)
//   addr_lo       in  2   byte offset within the word (bus_addr[1:0])
//   wdata         in  32  right-aligned store data
//   be            out 4   byte enables for the addressed lanes
//   wdata_steered out 32  store data replicated across lanes
//   misalign      out 1   half on an odd address, or word not on a word boundary
module bus_if_lane_align
  import bus_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_steered,
  output logic        misalign
);

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    be            = 4'b1111;
    wdata_steered = wdata;
    misalign      = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be            = 4'b0001 << addr_lo;
        wdata_steered = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be            = 4'b0011 << addr_lo;
        wdata_steered = {2{wdata[15:0]}};
        misalign      = addr_lo[0];
      end
      default: begin
        be            = 4'b1111;
        wdata_steered = wdata;
        misalign      = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/bus_if.sv
// bus_if: external bus interface downstream of the memory controller.
// Runs one load/store/fetch at a time as a req/ack transaction on the
// off-core bus: IDLE -> REQ -> ACK -> GAP -> IDLE (4 cycles minimum).
// Misaligned accesses skip the bus and go straight to ACK with bus_err.
// Optional feature macro: BUS_IF_TIMEOUT_EN aborts REQ after TIMEOUT_CYCLES
// cycles without ext_ack (bus_ack + bus_err, ext_read_data forced to 0).
// Ports:
//   clk, res_n                      clock, async active-low reset
//   bus_en/bus_wr_en/bus_addr/
//   bus_wr_data/bus_access_size     request from the memory controller
//   ext_read_data                   registered raw read word
//   bus_ack, bus_err                one-cycle completion / error pulses
//   ext_req/ext_we/ext_addr/
//   ext_wdata/ext_be                external bus request side
//   ext_rdata, ext_ack              external bus response side
module bus_if
  import bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        bus_en,
  input  logic        bus_wr_en,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wr_data,
  input  logic [1:0]  bus_access_size,
  output logic [31:0] ext_read_data,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_be,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misalign;
  logic        timeout;

  bus_if_lane_align u_lane_align (
    .size          (bus_access_size),
    .addr_lo       (bus_addr[1:0]),
    .wdata         (bus_wr_data),
    .be            (lane_be),
    .wdata_steered (lane_wdata),
    .misalign      (lane_misalign)
  );

`ifdef BUS_IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is held at zero outside REQ, so it is already clear on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_REQ) cnt_d = cnt_q + CNT_W'(1);
  end

  // The first REQ cycle sees cnt_q = 0, so TIMEOUT_CYCLES REQ cycles elapse
  // when cnt_q reaches TIMEOUT_CYCLES-1.
  assign timeout = (state_q == ST_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_en) begin
          addr_d  = {bus_addr[15:2], 2'b00};
          we_d    = bus_wr_en;
          wdata_d = lane_wdata;
          be_d    = lane_be;
          err_d   = lane_misalign;
          state_d = lane_misalign ? ST_ACK : ST_REQ;
        end
      end
      ST_REQ: begin
        if (ext_ack) begin
          if (!we_q) rdata_d = ext_rdata;
          state_d = ST_ACK;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_GAP;
      // bus_en is deliberately not looked at here: a request still held
      // after its ack must not be reissued.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  // All registers are plain flops (no arrays), so all are reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Decoded straight from state, so an async reset during REQ drops ext_req
  // immediately. Write enable and byte enables are only shown during REQ.
  assign ext_req       = (state_q == ST_REQ);
  assign ext_we        = ext_req & we_q;
  assign ext_be        = ext_req ? be_q : 4'b0000;
  assign ext_addr      = addr_q;
  assign ext_wdata     = wdata_q;
  assign bus_ack       = (state_q == ST_ACK);
  assign bus_err       = bus_ack & err_q;
  assign ext_read_data = rdata_q;

endmodule

// File: tb/tb_bus_if.sv
module tb_bus_if;

  logic        clk = 1'b0;
  logic        res_n;
  logic        bus_en;
  logic        bus_wr_en;
  logic [15:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [1:0]  bus_access_size;
  logic [31:0] ext_read_data;
  logic        bus_ack;
  logic        bus_err;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_be;
  logic [31:0] ext_rdata;
  logic        ext_ack;

  bus_if #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .res_n           (res_n),
    .bus_en          (bus_en),
    .bus_wr_en       (bus_wr_en),
    .bus_addr        (bus_addr),
    .bus_wr_data     (bus_wr_data),
    .bus_access_size (bus_access_size),
    .ext_read_data   (ext_read_data),
    .bus_ack         (bus_ack),
    .bus_err         (bus_err),
    .ext_req         (ext_req),
    .ext_we          (ext_we),
    .ext_addr        (ext_addr),
    .ext_wdata       (ext_wdata),
    .ext_be          (ext_be),
    .ext_rdata       (ext_rdata),
    .ext_ack         (ext_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          rise_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        req_prev = 1'b0;
  logic [31:0] model_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every bus_ack must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ext_req && !req_prev) rise_q.push_back(cyc);
    req_prev = ext_req;
    if (bus_ack) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(bus_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_rdata", ext_read_data, e.rdata);
        check("sb_err", 32'(bus_err), 32'(e.err));
      end
    end
  end

  // One transaction with controller handshake and external responder.
  task automatic do_txn(input string tag, input logic we, input logic [15:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input int delay, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic mis);
    exp_t e;
    @(negedge clk);
    bus_en = 1'b1; bus_wr_en = we; bus_addr = addr;
    bus_access_size = size; bus_wr_data = wdata;
    if (!mis && !we) model_rd = rdata;
    e.rdata = model_rd; e.err = mis;
    sb.push_back(e);
    @(negedge clk);
    if (mis) begin
      check({tag, "_noreq"}, 32'(ext_req), 32'd0);
      check({tag, "_ack"}, 32'(bus_ack), 32'd1);
      check({tag, "_err"}, 32'(bus_err), 32'd1);
    end else begin
      check({tag, "_req"}, 32'(ext_req), 32'd1);
      check({tag, "_addr"}, 32'(ext_addr), 32'({addr[15:2], 2'b00}));
      check({tag, "_be"}, 32'(ext_be), 32'(exp_be));
      check({tag, "_we"}, 32'(ext_we), 32'(we));
      if (we) check({tag, "_wdata"}, ext_wdata, exp_wd);
      // Controller-side inputs wander during REQ; the registered copy rules.
      bus_addr = ~addr; bus_wr_data = ~wdata; bus_wr_en = ~we;
      repeat (delay) @(negedge clk);
      check({tag, "_req_held"}, 32'(ext_req), 32'd1);
      check({tag, "_addr_held"}, 32'(ext_addr), 32'({addr[15:2], 2'b00}));
      ext_ack = 1'b1; ext_rdata = rdata;
      @(negedge clk);
      ext_ack = 1'b0; ext_rdata = 32'hDEAD_0000;
      check({tag, "_ack"}, 32'(bus_ack), 32'd1);
      check({tag, "_req_drop"}, 32'(ext_req), 32'd0);
    end
    bus_en = 1'b0;
    @(negedge clk);
    check({tag, "_gap_noack"}, 32'(bus_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int cnt;
    exp_t e;
    res_n = 1'b0; bus_en = 1'b0; bus_wr_en = 1'b0; bus_addr = '0;
    bus_wr_data = '0; bus_access_size = 2'b00; ext_rdata = '0; ext_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {27'd0, ext_req, bus_ack, bus_err, ext_we, 1'b0}, 32'd0);
    check("rst_be", 32'(ext_be), 32'd0);
    check("rst_addr", 32'(ext_addr), 32'd0);
    check("rst_wdata", ext_wdata, 32'd0);
    check("rst_rdata", ext_read_data, 32'd0);
    res_n = 1'b1;

    do_txn("wload", 1'b0, 16'h0010, 2'b10, 32'h0, 3, 32'hCAFE_BABE, 4'b1111, 32'h0, 1'b0);

`ifdef BUS_IF_TIMEOUT_EN
    @(negedge clk);
    bus_en = 1'b1; bus_wr_en = 1'b0; bus_addr = 16'h0050; bus_access_size = 2'b10;
    model_rd = '0; e.rdata = '0; e.err = 1'b1; sb.push_back(e);
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus_ack) break;
      if (ext_req) cnt++;
    end
    check("to_req_cycles", 32'(cnt), 32'd8);
    check("to_ack", 32'(bus_ack), 32'd1);
    check("to_err", 32'(bus_err), 32'd1);
    bus_en = 1'b0;
    @(negedge clk);
`else
    do_txn("longwait", 1'b0, 16'h0050, 2'b10, 32'h0, 20, 32'h1357_9BDF, 4'b1111, 32'h0, 1'b0);
`endif

    do_txn("bstore", 1'b1, 16'h0023, 2'b00, 32'hFFFF_FFA5, 2, 32'h0, 4'b1000, 32'hA5A5_A5A5, 1'b0);
    do_txn("hstore", 1'b1, 16'h0042, 2'b01, 32'h5555_BEEF, 1, 32'h0, 4'b1100, 32'hBEEF_BEEF, 1'b0);
    do_txn("bload", 1'b0, 16'h0001, 2'b00, 32'h0, 0, 32'h1122_3344, 4'b0010, 32'h0, 1'b0);
    do_txn("hmis", 1'b0, 16'h0031, 2'b01, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 1'b1);
    do_txn("wmis", 1'b0, 16'h0006, 2'b11, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 1'b1);
    do_txn("rsvload", 1'b0, 16'h0008, 2'b11, 32'h0, 0, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);

    // Back-to-back loads with bus_en held and immediate ext_ack.
    @(negedge clk);
    rise_q.delete();
    bus_en = 1'b1; bus_wr_en = 1'b0; bus_access_size = 2'b10; bus_addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      e.rdata = 32'h1000_0000 + 32'(i); e.err = 1'b0; sb.push_back(e);
    end
    model_rd = 32'h1000_0002;
    idx = 0;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      @(negedge clk);
      if (bus_ack) begin
        idx++;
        bus_addr = 16'(idx * 4);
        if (idx == 3) bus_en = 1'b0;
      end
      if (ext_req) begin
        check("b2b_addr", 32'(ext_addr), 32'(idx * 4));
        ext_ack = 1'b1; ext_rdata = 32'h1000_0000 + 32'(idx);
      end else begin
        ext_ack = 1'b0;
      end
    end
    ext_ack = 1'b0;
    check("b2b_done", 32'(idx), 32'd3);
    repeat (4) @(negedge clk);
    check("b2b_rises", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      check("b2b_period0", 32'(rise_q[1] - rise_q[0]), 32'd4);
      check("b2b_period1", 32'(rise_q[2] - rise_q[1]), 32'd4);
    end

    // Reset in the middle of REQ.
    @(negedge clk);
    bus_en = 1'b1; bus_wr_en = 1'b0; bus_addr = 16'h0060; bus_access_size = 2'b10;
    @(negedge clk);
    check("rstreq_req", 32'(ext_req), 32'd1);
    #2 res_n = 1'b0;
    #1 check("rstreq_drop", 32'(ext_req), 32'd0);
    bus_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;
    model_rd = '0;
    repeat (3) @(negedge clk);
    check("rstreq_idle_req", 32'(ext_req), 32'd0);
    check("rstreq_rdata", ext_read_data, 32'd0);

    do_txn("postrst", 1'b0, 16'h0004, 2'b10, 32'h0, 1, 32'h7777_8888, 4'b1111, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
